trash_compactor_stream: RTL and testbench

Parametrised streaming solver for the Day 6 worksheet (Part 1 semantics): accepts one BCD operand per beat over a valid/ready handshake, folds each group of `LINES` operands with the group's add/multiply operator, and sums all group results into a grand total. It replaces the fixed-size, two-word, always-ready front end with:

- configurable digit count, operand count and accumulator width;
- an explicit blank-digit code;
- an end-of-puzzle marker;
- output backpressure, plus sticky overflow and format-error flags.

---
 rtl/trash_compactor_stream.sv | 123 ++++++++++++
 tb/tb_trash_compactor_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trash_compactor_stream.sv
// trash_compactor_stream: streaming BCD worksheet solver folding LINES-operand problems into a grand total
module trash_compactor_stream #(
  parameter int DIGITS = 4,
  parameter int LINES = 4,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_op,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_result,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_overflow,
  output logic                out_error
);
  localparam int OPW = $clog2(10 ** DIGITS);
  localparam int IW = $clog2(LINES);
  localparam int W = ACC_W + OPW;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic alive, op_in, fire, idx_end, cur_op, blank, bad;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic [OPW-1:0] cv;
  logic s1_valid, s1_first, s1_end, s1_last, s1_op;
  logic [OPW-1:0] s1_val;
  logic s2_valid, s2_last, s3_done;
  logic [ACC_W-1:0] acc, total;
  logic [W-1:0] wide;
  logic [ACC_W:0] tsum;
  logic [CNT_W-1:0] count;
  logic ovf, err;
  assign in_ready = alive && state == RUN;
  assign out_valid = state == DONE;
  assign fire = in_valid && in_ready;
  assign idx_end = idx == IW'(LINES - 1);
  assign cur_op = idx == '0 ? in_op : op_in;
  assign wide = s1_op ? W'(acc) + W'(s1_val) : W'(acc) * W'(s1_val);
  assign tsum = {1'b0, total} + {1'b0, acc};
  assign out_result = total;
  assign out_count = count;
  assign out_overflow = ovf;
  assign out_error = err;
  // Horner over non-blank nibbles; an all-blank operand becomes the operator identity
  always_comb begin
    cv = '0;
    blank = 1'b1;
    bad = 1'b0;
    nib = 4'h0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = in_data[4*i +: 4];
      if (nib != 4'hF) begin
        cv = cv * OPW'(10) + OPW'(nib);
        blank = 1'b0;
      end
      if (nib > 4'h9 && nib != 4'hF) bad = 1'b1;
    end
    if (blank) cv = cur_op ? '0 : OPW'(1);
  end
  always_comb begin
    state_n = (state == RUN && fire && idx_end && in_last) ? DRAIN :
              (state == DRAIN && s3_done) ? DONE :
              (state == DONE && out_ready) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      alive <= 1'b0;
      idx <= '0;
      op_in <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_end <= 1'b0;
      s1_last <= 1'b0;
      s1_op <= 1'b0;
      s1_val <= '0;
      s2_valid <= 1'b0;
      s2_last <= 1'b0;
      s3_done <= 1'b0;
      acc <= '0;
      total <= '0;
      count <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      alive <= 1'b1;
      if (fire) begin
        idx <= idx_end ? '0 : idx + IW'(1);
        if (idx == '0) op_in <= in_op;
        s1_val <= cv;
        s1_first <= idx == '0;
        s1_end <= idx_end;
        s1_last <= idx_end && in_last;
        s1_op <= cur_op;
      end
      s1_valid <= fire;
      s2_valid <= s1_valid && s1_end;
      s2_last <= s1_valid && s1_end && s1_last;
      s3_done <= s2_last;
      if (s1_valid) acc <= s1_first ? ACC_W'(s1_val) : wide[ACC_W-1:0];
      if (state == DONE && out_ready) begin
        total <= '0;
        count <= '0;
        ovf <= 1'b0;
        err <= 1'b0;
      end else begin
        if (s2_valid) begin
          total <= tsum[ACC_W-1:0];
          count <= count + CNT_W'(1);
        end
        ovf <= ovf | (s1_valid && !s1_first && |wide[W-1:ACC_W]) | (s2_valid && tsum[ACC_W]);
        err <= err | (fire && bad);
      end
    end
  end
endmodule

// File: tb/tb_trash_compactor_stream.sv
// tb_trash_compactor_stream: scoreboard bench driving a 64-bit and a 16-bit accumulator instance in lockstep
module tb_trash_compactor_stream;
  logic clk = 0, rst = 1, in_valid = 0, in_op = 0, in_last = 0, out_ready = 0, tb_final = 0;
  logic [11:0] in_data = '1;
  logic in_ready, out_valid, ovf, err, in_ready16, out_valid16, ovf16, err16;
  logic [63:0] res;
  logic [15:0] cnt, res16, cnt16;
  int errors = 0, checks = 0;
  typedef struct {longint unsigned r64; longint unsigned r16; int cnt; bit e; bit o16;} exp_t;
  exp_t sb[$];
  logic [11:0] pz_data[$];
  bit pz_op[$];
  always #5 clk = ~clk;
  trash_compactor_stream #(.DIGITS(3), .LINES(3), .ACC_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(res), .out_count(cnt), .out_overflow(ovf), .out_error(err));
  trash_compactor_stream #(.DIGITS(3), .LINES(3), .ACC_W(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
    .out_result(res16), .out_count(cnt16), .out_overflow(ovf16), .out_error(err16));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  task automatic abort(input string name);
    errors++;
    checks++;
    $display("FAIL %s: bounded wait expired", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  endtask
  function automatic longint unsigned conv(input logic [11:0] d, input bit op);
    longint unsigned v = 0;
    bit any = 0;
    logic [3:0] n;
    for (int i = 2; i >= 0; i--) begin
      n = d[4*i +: 4];
      if (n != 4'hF) begin
        v = v * 10 + longint'(n);
        any = 1;
      end
    end
    return any ? v : (op ? 0 : 1);
  endfunction
  function automatic bit is_bad(input logic [11:0] d);
    logic [3:0] n;
    bit b = 0;
    for (int i = 0; i < 3; i++) begin
      n = d[4*i +: 4];
      if (n > 9 && n != 4'hF) b = 1;
    end
    return b;
  endfunction
  function automatic logic [11:0] rand_operand();
    logic [11:0] d;
    for (int i = 0; i < 3; i++) d[4*i +: 4] = ($urandom % 4 == 0) ? 4'hF : 4'($urandom % 10);
    if ($urandom % 10 == 0) d = '1;
    if ($urandom % 25 == 0) begin
      d[3:0] = 4'($urandom_range(10, 14));
      if (d[11:8] != 4'hF && d[11:8] > 8) d[11:8] = 4'h8;
    end
    return d;
  endfunction
  task automatic beat(input logic [11:0] d, input bit op, input bit last, input bit fin);
    in_valid = 1;
    in_data = d;
    in_op = op;
    in_last = last;
    tb_final = fin;
    for (int t = 0; !in_ready; t++) begin
      if (t > 200) abort("in_ready_wait");
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask
  task automatic wait_result(input int hold);
    for (int t = 0; !out_valid; t++) begin
      if (t > 50) abort("out_valid_wait");
      @(posedge clk); #1;
    end
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  // expected totals come straight from the worksheet rules, with 2^16 wrap tracked separately
  task automatic run_puzzle(input int hold, input bit pre, input bit noise);
    exp_t x;
    longint unsigned a, a16, v;
    int np;
    np = pz_op.size();
    x.r64 = 0; x.r16 = 0; x.e = 0; x.o16 = 0; x.cnt = np;
    a = 0; a16 = 0;
    for (int p = 0; p < np; p++) begin
      for (int j = 0; j < 3; j++) begin
        v = conv(pz_data[3*p+j], pz_op[p]);
        if (is_bad(pz_data[3*p+j])) x.e = 1;
        if (j == 0) begin a = v; a16 = v; end
        else if (pz_op[p]) begin a += v; a16 += v; end
        else begin a *= v; a16 *= v; end
        if (a16 >= 65536) x.o16 = 1;
        a16 %= 65536;
      end
      x.r64 += a;
      x.r16 += a16;
      if (x.r16 >= 65536) x.o16 = 1;
      x.r16 %= 65536;
    end
    for (int t = 0; !in_ready; t++) begin
      if (t > 50) abort("idle_wait");
      @(posedge clk); #1;
    end
    sb.push_back(x);
    out_ready = pre;
    for (int p = 0; p < np; p++)
      for (int j = 0; j < 3; j++) begin
        if (noise && $urandom % 4 == 0) begin
          in_valid = 0;
          @(posedge clk); #1;
        end
        beat(pz_data[3*p+j],
             (j == 0 || !noise) ? pz_op[p] : 1'($urandom % 2),
             j == 2 ? (p == np - 1) : (noise ? 1'($urandom % 2) : 1'b0),
             j == 2 && p == np - 1);
      end
    in_valid = 0;
    in_last = 0;
    tb_final = 0;
    pz_data.delete();
    pz_op.delete();
    if (!pre) wait_result(hold);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {in_ready, in_ready16}, 0);
    chk({tag, "_out_valid"}, {out_valid, out_valid16}, 0);
    chk({tag, "_result"}, res | 64'(res16), 0);
    chk({tag, "_count_flags"}, {cnt, cnt16, ovf, err, ovf16, err16}, 0);
  endtask
  // monitor: pops on every output handshake and polices latency, stability and in_ready
  int cyc = 0, acc_cyc = 0;
  bit pending = 0, pv = 0, pr = 0, back = 0;
  logic [63:0] s_res;
  logic [63:0] s_rest;
  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (rst) begin
      pending = 0; pv = 0; pr = 0; back = 0;
    end else begin
      if (back) begin
        chk("in_ready_return", {in_ready, in_ready16, out_valid}, 3'b110);
        back = 0;
      end
      if (pending && cyc > acc_cyc && !out_valid) chk("in_ready_drain", {in_ready, in_ready16}, 0);
      if (out_valid) chk("in_ready_done", {in_ready, in_ready16}, 0);
      if (pending && cyc == acc_cyc + 4) begin
        chk("latency_T3", {out_valid, pv}, 2'b10);
        pending = 0;
      end
      if (out_valid && pv && !pr) begin
        chk("stable_result", res, s_res);
        chk("stable_rest", {cnt, ovf, err, res16, cnt16, ovf16, err16}, s_rest);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          x = sb.pop_front();
          chk("result", res, x.r64);
          chk("count", cnt, 64'(x.cnt));
          chk("overflow", ovf, 0);
          chk("error", err, 64'(x.e));
          chk("result16", res16, x.r16);
          chk("count16", cnt16, 64'(x.cnt));
          chk("overflow16", ovf16, 64'(x.o16));
          chk("error16", err16, 64'(x.e));
          chk("valid16", out_valid16, 1);
        end
        back = 1;
      end
      if (in_valid && in_ready && tb_final) begin
        pending = 1;
        acc_cyc = cyc;
      end
      pv = out_valid;
      pr = out_ready;
      s_res = res;
      s_rest = 64'({cnt, ovf, err, res16, cnt16, ovf16, err16});
    end
  end
  initial begin
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    pz_data = '{12'h123, 12'hF45, 12'hFF6, 12'h328, 12'h64F, 12'h98F,
                12'hF51, 12'h387, 12'h215, 12'h64F, 12'h23F, 12'h314};
    pz_op = '{0, 1, 0, 1};
    run_puzzle(10, 0, 0);
    pz_data = '{12'hFF2, 12'hFF3, 12'hFF4};
    pz_op = '{0};
    run_puzzle(0, 0, 0);
    pz_data = '{12'hFFF, 12'h007, 12'hFFF, 12'hFFF, 12'hFFF, 12'h005};
    pz_op = '{0, 1};
    run_puzzle(2, 0, 0);
    pz_data = '{12'h1A3, 12'h002, 12'hFFF};
    pz_op = '{1};
    run_puzzle(1, 0, 0);
    pz_data = '{12'hFF1, 12'hFF1, 12'hFF1};
    pz_op = '{1};
    run_puzzle(0, 0, 0);
    pz_data = '{12'h999, 12'h999, 12'h999};
    pz_op = '{0};
    run_puzzle(0, 1, 0);
    for (int t = 0; !in_ready; t++) begin
      if (t > 50) abort("pre_reset_idle");
      @(posedge clk); #1;
    end
    out_ready = 0;
    beat(12'hFF7, 0, 0, 0);
    beat(12'hFF8, 0, 0, 0);
    in_valid = 0;
    rst = 1;
    #2 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_mid_reset", in_ready, 1);
    pz_data = '{12'hFF1, 12'hFF1, 12'hFF1};
    pz_op = '{1};
    run_puzzle(0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      int np;
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        pz_op.push_back(1'($urandom % 2));
        for (int j = 0; j < 3; j++) pz_data.push_back(rand_operand());
      end
      run_puzzle($urandom_range(0, 3), 1'($urandom % 2), 1);
    end
    for (int t = 0; sb.size() != 0 && t < 100; t++) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
